uart_pic_tx: RTL

Image readback transmitter for the RS-232 picture path. On a start pulse it reads every byte of the picture RAM in address order, 0 to IMAGE_SIZE-1. It serializes each byte onto the UART TX line as 8N1, LSB first. It is the return direction of the RX-to-picture-RAM path: the host can dump the frame buffer back and compare it against what it sent.

---
 rtl/uart_pic_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_pic_tx.sv
// uart_pic_tx: on a start pulse, reads the picture RAM from address 0 to
// IMAGE_SIZE-1 and sends every byte on the UART TX line as 8N1, LSB first.
// Optional feature macro: UART_PIC_TX_CHECKSUM_EN appends one extra frame
// carrying the mod-256 sum of all image bytes.
module uart_pic_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int IMAGE_SIZE = 10000,
    parameter int ADDR_W     = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BAUD_W       = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [3:0]        STOP_BIT  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                w_rd_en;
    logic                w_bit_end;
    logic                w_frame_end;
    logic                w_last_addr;
`ifdef UART_PIC_TX_CHECKSUM_EN
    logic [7:0]          r_csum;
    logic                r_csum_frame;
`endif

    assign w_bit_end   = (r_state == SEND) && (r_baud_cnt == BAUD_LAST);
    assign w_frame_end = w_bit_end && (r_bit_cnt == STOP_BIT);
    assign w_last_addr = (r_addr == LAST_ADDR);

    assign rd_en   = w_rd_en;
    assign rd_addr = r_addr;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state decode and RAM read strobe.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_next = FETCH;
            FETCH: begin
                w_rd_en      = 1'b1;
                w_state_next = LOAD;
            end
            LOAD:  w_state_next = SEND;
            SEND: begin
                if (w_frame_end) begin
                    if (!w_last_addr) begin
                        w_state_next = FETCH;
                    end else begin
`ifdef UART_PIC_TX_CHECKSUM_EN
                        // The checksum is already on-chip, so its frame
                        // starts right after the last image stop bit.
                        w_state_next = r_csum_frame ? IDLE : SEND;
`else
                        w_state_next = IDLE;
`endif
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Serializer datapath: address, shift register, bit/baud counters, line.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_PIC_TX_CHECKSUM_EN
            r_csum       <= '0;
            r_csum_frame <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (start) begin
                        r_addr <= '0;
                        r_busy <= 1'b1;
`ifdef UART_PIC_TX_CHECKSUM_EN
                        r_csum       <= '0;
                        r_csum_frame <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    r_tx <= 1'b1;
                end
                LOAD: begin
                    r_shift    <= rd_data;
                    r_tx       <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
`ifdef UART_PIC_TX_CHECKSUM_EN
                    r_csum <= r_csum + rd_data;
`endif
                end
                SEND: begin
                    if (!w_bit_end) begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end else begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt != STOP_BIT) begin
                            // Present the next bit: data LSB first, then stop.
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= (r_bit_cnt == 4'd8) ? 1'b1 : r_shift[r_bit_cnt[2:0]];
                        end else if (!w_last_addr) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end else begin
`ifdef UART_PIC_TX_CHECKSUM_EN
                            if (!r_csum_frame) begin
                                r_shift      <= r_csum;
                                r_tx         <= 1'b0;
                                r_bit_cnt    <= '0;
                                r_csum_frame <= 1'b1;
                            end else begin
                                r_done <= 1'b1;
                                r_busy <= 1'b0;
                            end
`else
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
`endif
                        end
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule
